// File: rtl/term_vram_sched.sv
// term_vram_sched: owns the text VRAM write/read ports; host char writes vs bulk clear/scroll.
// Optional TERM_VRAM_SCHED_HOST_QUEUE_EN: one-entry host write holding register while busy.
module term_vram_sched #(
    parameter int         COLS      = 100,
    parameter int         ROWS      = 30,
    parameter int         ADDR_W    = 12,
    parameter logic [7:0] FILL_CHAR = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_data,
    output logic              host_gnt,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [4:0]        cmd_row,
    output logic              cmd_ready,
    output logic              busy,
    output logic              done,
    output logic              vram_w_en,
    output logic [ADDR_W-1:0] vram_w_addr,
    output logic [7:0]        vram_w_data,
    output logic [ADDR_W-1:0] vram_r_addr,
    input  logic [7:0]        vram_r_data
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        COPY,
        FILL,
        FIN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

    state_t            state;
    state_t            state_n;
    logic              w_en_n;
    logic [ADDR_W-1:0] w_addr_n;
    logic [7:0]        w_data_q;
    logic [7:0]        w_data_n;
    logic              copy_q;
    logic              copy_n;
    logic [ADDR_W-1:0] r_addr_n;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] last_n;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] row_last;
    logic              row_ok;
    logic              q_empty;

    assign row_base = ADDR_W'(cmd_row) * COLS_A;
    assign row_last = row_base + COLS_A - ONE;
    assign row_ok   = int'(cmd_row) < ROWS;

    assign busy = (state != IDLE);
    assign done = (state == FIN);

    // During scroll copy the read data flows straight onto the write bus.
    assign vram_w_data = copy_q ? vram_r_data : w_data_q;

`ifdef TERM_VRAM_SCHED_HOST_QUEUE_EN
    logic              q_valid;
    logic              q_valid_n;
    logic [ADDR_W-1:0] q_addr;
    logic [ADDR_W-1:0] q_addr_n;
    logic [7:0]        q_data;
    logic [7:0]        q_data_n;

    assign q_empty = !q_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_addr  <= '0;
            q_data  <= 8'h00;
        end else begin
            q_valid <= q_valid_n;
            q_addr  <= q_addr_n;
            q_data  <= q_data_n;
        end
    end
`else
    assign q_empty = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vram_w_en   <= 1'b0;
            vram_w_addr <= '0;
            w_data_q    <= 8'h00;
            copy_q      <= 1'b0;
            vram_r_addr <= '0;
            last_q      <= '0;
        end else begin
            vram_w_en   <= w_en_n;
            vram_w_addr <= w_addr_n;
            w_data_q    <= w_data_n;
            copy_q      <= copy_n;
            vram_r_addr <= r_addr_n;
            last_q      <= last_n;
        end
    end

    always_comb begin
        state_n   = state;
        w_en_n    = 1'b0;
        w_addr_n  = vram_w_addr;
        w_data_n  = w_data_q;
        copy_n    = 1'b0;
        r_addr_n  = vram_r_addr;
        last_n    = last_q;
        host_gnt  = 1'b0;
        cmd_ready = 1'b0;
`ifdef TERM_VRAM_SCHED_HOST_QUEUE_EN
        q_valid_n = q_valid;
        q_addr_n  = q_addr;
        q_data_n  = q_data;
`endif
        unique case (state)
            IDLE: begin
                host_gnt  = host_req;
                cmd_ready = !host_req && q_empty;
                if (host_req) begin
                    w_en_n   = 1'b1;
                    w_addr_n = host_addr;
                    w_data_n = host_data;
                end else if (cmd_valid && cmd_ready) begin
                    unique case (cmd_op)
                        2'b00: begin
                            state_n  = CLEAR;
                            w_en_n   = 1'b1;
                            w_addr_n = '0;
                            w_data_n = FILL_CHAR;
                            last_n   = LAST;
                        end
                        2'b01: begin
                            state_n  = COPY;
                            r_addr_n = COLS_A;
                        end
                        2'b10: begin
                            if (row_ok) begin
                                state_n  = CLEAR;
                                w_en_n   = 1'b1;
                                w_addr_n = row_base;
                                w_data_n = FILL_CHAR;
                                last_n   = row_last;
                            end else begin
                                state_n = FIN;
                            end
                        end
                        default: state_n = FIN;
                    endcase
                end
            end
            CLEAR: begin
                if (vram_w_addr == last_q) begin
                    state_n = FIN;
                end else begin
                    w_en_n   = 1'b1;
                    w_addr_n = vram_w_addr + ONE;
                end
            end
            COPY: begin
                // Write lands one cycle behind the read, one row up.
                w_en_n   = 1'b1;
                copy_n   = 1'b1;
                w_addr_n = vram_r_addr - COLS_A;
                if (vram_r_addr == LAST) begin
                    state_n = FILL;
                end else begin
                    r_addr_n = vram_r_addr + ONE;
                end
            end
            FILL: begin
                w_data_n = FILL_CHAR;
                if (vram_w_addr == LAST) begin
                    state_n = FIN;
                end else begin
                    w_en_n   = 1'b1;
                    w_addr_n = vram_w_addr + ONE;
                end
            end
            FIN: begin
                state_n = IDLE;
`ifdef TERM_VRAM_SCHED_HOST_QUEUE_EN
                if (q_valid) begin
                    w_en_n    = 1'b1;
                    w_addr_n  = q_addr;
                    w_data_n  = q_data;
                    q_valid_n = 1'b0;
                end else if (host_req) begin
                    host_gnt = 1'b1;
                    w_en_n   = 1'b1;
                    w_addr_n = host_addr;
                    w_data_n = host_data;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
`ifdef TERM_VRAM_SCHED_HOST_QUEUE_EN
        if ((state inside {CLEAR, COPY, FILL}) && host_req && q_empty) begin
            host_gnt  = 1'b1;
            q_valid_n = 1'b1;
            q_addr_n  = host_addr;
            q_data_n  = host_data;
        end
`endif
    end

endmodule

// File: tb/tb_term_vram_sched.sv
// tb_term_vram_sched: directed bench for term_vram_sched with a VRAM model.
// Honours TERM_VRAM_SCHED_HOST_QUEUE_EN to pick the busy-host expectation.
module tb_term_vram_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_req = 1'b0;
    logic [11:0] host_addr = '0;
    logic [7:0]  host_data = '0;
    logic        host_gnt;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = '0;
    logic [4:0]  cmd_row = '0;
    logic        cmd_ready;
    logic        busy;
    logic        done;
    logic        vram_w_en;
    logic [11:0] vram_w_addr;
    logic [7:0]  vram_w_data;
    logic [11:0] vram_r_addr;
    logic [7:0]  rd;

    always #5 clk = ~clk;

    term_vram_sched dut (
        .clk(clk), .rst_n(rst_n),
        .host_req(host_req), .host_addr(host_addr),
        .host_data(host_data), .host_gnt(host_gnt),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_row(cmd_row), .cmd_ready(cmd_ready),
        .busy(busy), .done(done),
        .vram_w_en(vram_w_en), .vram_w_addr(vram_w_addr),
        .vram_w_data(vram_w_data), .vram_r_addr(vram_r_addr),
        .vram_r_data(rd)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // VRAM model: registered read, optional bulk preload
    logic [7:0] mem [0:4095];
    logic       pre_go = 1'b0;
    logic       pre_rows = 1'b0;

    always @(posedge clk) begin
        rd <= mem[vram_r_addr];
        if (pre_go) begin
            for (int a = 0; a < 4096; a++)
                mem[a] <= (pre_rows && a < 3000) ? 8'(65 + a / 100) : 8'hFF;
        end else if (vram_w_en) begin
            mem[vram_w_addr] <= vram_w_data;
        end
    end

    // write/done monitor
    int          nwr, fcyc, lcyc, seq_err, nzero, dcnt, dcyc;
    logic [11:0] amin, amax, prev;

    always @(negedge clk) begin
        if (vram_w_en) begin
            if (nwr == 0) fcyc = cyc;
            else if (vram_w_addr != prev + 12'd1) seq_err++;
            lcyc = cyc;
            prev = vram_w_addr;
            nwr++;
            if (vram_w_data != 8'h00) nzero++;
            if (vram_w_addr < amin) amin = vram_w_addr;
            if (vram_w_addr > amax) amax = vram_w_addr;
        end
        if (done) begin
            dcnt++;
            dcyc = cyc;
        end
    end

    task automatic clr_mon();
        nwr = 0; fcyc = -1; lcyc = -1; seq_err = 0; nzero = 0;
        dcnt = 0; dcyc = -1; amin = 12'hFFF; amax = 12'h000; prev = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] row,
                         output int t);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_row = row;
        #1;
        chk("cmd_ready", 32'(cmd_ready), 1);
        t = cyc;
        clr_mon();
        tick();
        cmd_valid = 1'b0;
        cmd_op = 2'b01;
        cmd_row = 5'd0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && dcnt == 0; i++) tick();
    endtask

    task automatic preload(input logic rows);
        pre_rows = rows;
        pre_go = 1'b1;
        tick();
        pre_go = 1'b0;
    endtask

    task automatic scroll_mem_check(input logic skip5);
        int bad_rows, bad_fill;
        bad_rows = 0;
        bad_fill = 0;
        for (int a = 0; a < 2900; a++)
            if (!(skip5 && a == 5) && mem[a] !== 8'(66 + a / 100)) bad_rows++;
        for (int a = 2900; a < 3000; a++)
            if (mem[a] !== 8'h00) bad_fill++;
        chk("scroll_rows", 32'(bad_rows), 0);
        chk("scroll_fill", 32'(bad_fill), 0);
        chk("scroll_no_overrun", 32'(mem[3000]), 32'hFF);
    endtask

    initial begin
        int t;
        int bad;
        clr_mon();
        tick(); tick(); tick();
        chk("rst_w_en", 32'(vram_w_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_w_addr", 32'(vram_w_addr), 0);
        chk("rst_w_data", 32'(vram_w_data), 0);
        chk("rst_r_addr", 32'(vram_r_addr), 0);
        rst_n = 1'b1;
        tick();

        // single host write
        host_req = 1'b1; host_addr = 12'h123; host_data = 8'h41;
        #1;
        chk("host_gnt", 32'(host_gnt), 1);
        tick();
        host_req = 1'b0;
        chk("host_w_en", 32'(vram_w_en), 1);
        chk("host_w_addr", 32'(vram_w_addr), 32'h123);
        chk("host_w_data", 32'(vram_w_data), 32'h41);
        tick();
        chk("host_w_en_off", 32'(vram_w_en), 0);

        // collision, then clear-row 5
        host_req = 1'b1; host_addr = 12'h0AA; host_data = 8'h33;
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_row = 5'd5;
        #1;
        chk("coll_host_gnt", 32'(host_gnt), 1);
        chk("coll_cmd_ready", 32'(cmd_ready), 0);
        tick();
        host_req = 1'b0;
        chk("coll_w_addr", 32'(vram_w_addr), 32'h0AA);
        issue(2'b10, 5'd5, t);
        wait_done(300);
        chk("row5_done_seen", 32'(dcnt), 1);
        chk("row5_done_cyc", 32'(dcyc), 32'(t + 101));
        chk("row5_nwr", 32'(nwr), 100);
        chk("row5_first", 32'(fcyc), 32'(t + 1));
        chk("row5_amin", 32'(amin), 500);
        chk("row5_amax", 32'(amax), 599);
        chk("row5_seq", 32'(seq_err), 0);
        chk("row5_data", 32'(nzero), 0);
        tick();
        chk("row5_busy_off", 32'(busy), 0);

        // out-of-range row and reserved op
        issue(2'b10, 5'd31, t);
        chk("row31_done_cyc", 32'(dcyc), 32'(t + 1));
        chk("row31_nwr", 32'(nwr), 0);
        tick();
        issue(2'b11, 5'd0, t);
        chk("rsv_done_cyc", 32'(dcyc), 32'(t + 1));
        chk("rsv_nwr", 32'(nwr), 0);
        tick();

        // clear-all
        preload(1'b0);
        issue(2'b00, 5'd0, t);
        wait_done(4000);
        chk("clr_done_seen", 32'(dcnt), 1);
        chk("clr_done_cyc", 32'(dcyc), 32'(t + 3001));
        chk("clr_nwr", 32'(nwr), 3000);
        chk("clr_first", 32'(fcyc), 32'(t + 1));
        chk("clr_last", 32'(lcyc), 32'(t + 3000));
        chk("clr_amax", 32'(amax), 2999);
        chk("clr_amin", 32'(amin), 0);
        chk("clr_seq", 32'(seq_err), 0);
        chk("clr_data", 32'(nzero), 0);
        tick();
        chk("clr_busy_off", 32'(busy), 0);
        chk("clr_done_once", 32'(dcnt), 1);
        bad = 0;
        for (int a = 0; a < 3000; a++)
            if (mem[a] !== 8'h00) bad++;
        chk("clr_mem", 32'(bad), 0);
        chk("clr_no_overrun", 32'(mem[3000]), 32'hFF);

        // scroll-up
        preload(1'b1);
        issue(2'b01, 5'd0, t);
        wait_done(4000);
        chk("scr_done_cyc", 32'(dcyc), 32'(t + 3002));
        chk("scr_nwr", 32'(nwr), 3000);
        chk("scr_first", 32'(fcyc), 32'(t + 2));
        chk("scr_last", 32'(lcyc), 32'(t + 3001));
        chk("scr_amax", 32'(amax), 2999);
        chk("scr_seq", 32'(seq_err), 0);
        tick();
        chk("scr_busy_off", 32'(busy), 0);
        scroll_mem_check(1'b0);

        // scroll with a host write arriving while busy
        preload(1'b1);
        issue(2'b01, 5'd0, t);
        for (int i = 0; i < 9; i++) tick();
        host_req = 1'b1; host_addr = 12'h005; host_data = 8'h7A;
        #1;
`ifdef TERM_VRAM_SCHED_HOST_QUEUE_EN
        chk("busy_host_gnt", 32'(host_gnt), 1);
`else
        chk("busy_host_gnt", 32'(host_gnt), 0);
`endif
        tick();
        chk("busy_host_gnt2", 32'(host_gnt), 0);
        host_req = 1'b0;
        wait_done(4000);
        chk("q_done_cyc", 32'(dcyc), 32'(t + 3002));
        chk("q_nwr", 32'(nwr), 3000);
        tick();
        chk("q_busy_off", 32'(busy), 0);
`ifdef TERM_VRAM_SCHED_HOST_QUEUE_EN
        chk("q_w_en", 32'(vram_w_en), 1);
        chk("q_w_addr", 32'(vram_w_addr), 5);
        chk("q_w_data", 32'(vram_w_data), 32'h7A);
        tick();
        chk("q_mem5", 32'(mem[5]), 32'h7A);
`else
        chk("q_w_en", 32'(vram_w_en), 0);
        tick();
        chk("q_mem5", 32'(mem[5]), 32'h42);
`endif
        scroll_mem_check(1'b1);
        tick();

        // reset in the middle of clear-all
        issue(2'b00, 5'd0, t);
        for (int i = 0; i < 1499; i++) tick();
        chk("mid_w_en", 32'(vram_w_en), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_w_en", 32'(vram_w_en), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_w_addr", 32'(vram_w_addr), 0);
        tick(); tick(); tick();
        chk("mid_rst_nwr", 32'(nwr), 1500);
        chk("mid_rst_no_done", 32'(dcnt), 0);
        rst_n = 1'b1;
        tick();
        host_req = 1'b1; host_addr = 12'h7FF; host_data = 8'h55;
        #1;
        chk("post_rst_gnt", 32'(host_gnt), 1);
        tick();
        host_req = 1'b0;
        chk("post_rst_w_en", 32'(vram_w_en), 1);
        chk("post_rst_w_addr", 32'(vram_w_addr), 32'h7FF);
        chk("post_rst_w_data", 32'(vram_w_data), 32'h55);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/term_vram_sched.md
Name: term_vram_sched

Overview:
- Sole owner of the text VRAM write port and one VRAM read port in the terminal display path.
- Shares the write port between the terminal engine (single-character writes) and an internal bulk engine that executes three commands: clear-screen, clear-row and scroll-up-one-line.
- Scroll-up replaces cursor wrap-to-row-0 with real terminal scrolling.
- Sits between the terminal state machine and video_ram; the display read port is unaffected.

Parameters:
- COLS, 100, characters per row.
- ROWS, 30, rows per screen.
- ADDR_W, 12, VRAM address width; must satisfy COLS*ROWS <= 2^ADDR_W.
- FILL_CHAR, 8'h00, code written by clear and by the scroll fill.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- host_req  in  1  terminal engine requests one write.
- host_addr  in  ADDR_W  write address.
- host_data  in  8  write data.
- host_gnt  out  1  combinational; the write is taken in a cycle where host_req && host_gnt.
- cmd_valid  in  1  bulk command request.
- cmd_op  in  2  00 clear-all, 01 scroll-up, 10 clear-row, 11 reserved.
- cmd_row  in  5  row index for clear-row.
- cmd_ready  out  1  combinational; the command is accepted in a cycle where cmd_valid && cmd_ready.
- busy  out  1  bulk engine active.
- done  out  1  one-cycle pulse at command completion.
- vram_w_en  out  1  registered write strobe.
- vram_w_addr  out  ADDR_W  registered write address.
- vram_w_data  out  8  write data.
- vram_r_addr  out  ADDR_W  registered read address.
- vram_r_data  in  8  read data; valid one cycle after vram_r_addr.

Behaviour:
- Reset (async, immediate):
  - state IDLE.
  - busy=0, done=0, vram_w_en=0.
  - vram_w_addr=0, vram_w_data=0, vram_r_addr=0.
  - An in-flight command is abandoned: no further writes and no done pulse.
- States: IDLE, CLEAR, COPY, FILL, FIN.
- Arbitration in IDLE:
  - host_gnt = host_req.
  - cmd_ready = !host_req, so a host write wins a same-cycle collision and the command waits.
  - Outside IDLE: host_gnt=0 (see Optional Feature) and cmd_ready=0.
- Host write: granted in cycle T, so vram_w_en=1 at T+1 with the captured addr/data. Throughput is 1 write/cycle.
- The command is accepted in cycle T. busy=1 from T+1 until the done cycle inclusive. busy=0 the following cycle.
- clear-all (00): CLEAR writes FILL_CHAR to addresses 0..COLS*ROWS-1, one per cycle, at T+1..T+3000. FIN follows, and done=1 at T+3001.
- clear-row (10):
  - Writes FILL_CHAR to cmd_row*COLS .. cmd_row*COLS+COLS-1 at T+1..T+100; done at T+101.
  - If cmd_row >= ROWS: no writes, done at T+1.
- scroll-up (01):
  - COPY: vram_r_addr steps COLS..COLS*ROWS-1 from T+1. Each read's data is written to read address minus COLS one cycle later, with vram_w_data = vram_r_data.
  - COPY writes occur at T+2..T+2901, addresses 0..2899.
  - FILL: writes FILL_CHAR to 2900..2999 at T+2902..T+3001. done at T+3002.
- Reserved op 11: accepted, no writes, done at T+1.
- Address arithmetic is unsigned ADDR_W. Counters stop exactly at the last address, with no overrun write.
- cmd_op and cmd_row are sampled only in the accept cycle. Later changes are ignored.
- done and a new accept cannot coincide; a new command is accepted no earlier than the cycle after done.

Optional Feature:
- Macro: TERM_VRAM_SCHED_HOST_QUEUE_EN.
- Enabled:
  - A one-entry holding register accepts a host write while busy. host_gnt = host_req && queue empty.
  - The queued write is issued (vram_w_en=1) in the first cycle after done, before any new command.
  - cmd_ready stays 0 while the queue is non-empty.
- Disabled: host_gnt=0 whenever the state is not IDLE; no holding register.

Test Plan:
- Reset then host_req with addr 0x123 and data 0x41 for 1 cycle -> host_gnt=1 same cycle; next cycle vram_w_en=1, addr 0x123, data 0x41.
- clear-all accepted at T -> exactly 3000 writes of 0x00 to 0..2999 at T+1..T+3000; done single pulse at T+3001; busy low at T+3002.
- VRAM model preloaded with row r filled with 'A'+r, then scroll-up -> rows 0..28 hold 'B'..'^'; row 29 all 0x00; done at T+3002.
- clear-row with cmd_row=5 -> writes only 500..599; cmd_row=31 -> zero writes, done at T+1.
- host_req and cmd_valid in the same IDLE cycle -> host granted and cmd_ready=0; command accepted the next cycle.
- rst_n low at T+1500 of clear-all -> vram_w_en drops immediately, no done; after release a host write is granted normally.
- With TERM_VRAM_SCHED_HOST_QUEUE_EN: host write 0x05/0x7A during scroll is granted once and written in the cycle after done; without the macro, host_gnt=0 throughout busy.
